// File: rtl/bp_be_instr_decode_stage.sv
// RV64 backend decode stage: splits raw instructions into a micro-op and buffers it in a 2-entry FIFO.
// Optional macro BP_BE_DECODE_RV64M_EN enables decoding of the M extension (op class MULDIV).
module bp_be_instr_decode_stage #(
    parameter int eaddr_width_p    = 64,
    parameter int instr_width_p    = 32,
    parameter int reg_addr_width_p = 5,
    parameter int els_p            = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    input  logic                        v_i,
    output logic                        ready_o,
    input  logic [instr_width_p-1:0]    instr_i,
    input  logic [eaddr_width_p-1:0]    pc_i,
    output logic                        v_o,
    input  logic                        yumi_i,
    output logic [eaddr_width_p-1:0]    pc_o,
    output logic [instr_width_p-1:0]    instr_o,
    output logic [reg_addr_width_p-1:0] rs1_addr_o,
    output logic [reg_addr_width_p-1:0] rs2_addr_o,
    output logic [reg_addr_width_p-1:0] rd_addr_o,
    output logic                        rs1_r_v_o,
    output logic                        rs2_r_v_o,
    output logic                        irf_w_v_o,
    output logic [63:0]                 imm_o,
    output logic [3:0]                  op_class_o,
    output logic                        illegal_o
);

    typedef enum logic [3:0] {
        CLS_ALU     = 4'd0,
        CLS_ALU_W   = 4'd1,
        CLS_MULDIV  = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JALR    = 4'd7,
        CLS_LUI     = 4'd8,
        CLS_AUIPC   = 4'd9,
        CLS_SYS     = 4'd10,
        CLS_ILLEGAL = 4'd15
    } op_class_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [eaddr_width_p-1:0]    pc;
        logic [instr_width_p-1:0]    instr;
        logic [reg_addr_width_p-1:0] rs1;
        logic [reg_addr_width_p-1:0] rs2;
        logic [reg_addr_width_p-1:0] rd;
        logic                        rs1_r_v;
        logic                        rs2_r_v;
        logic                        irf_w_v;
        logic [63:0]                 imm;
        op_class_e                   op_class;
        logic                        illegal;
    } uop_t;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic legal;
    uop_t dec;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
    assign imm_j = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        // NOTE: every field gets a default first so no path can infer a latch.
        dec          = '0;
        dec.pc       = pc_i;
        dec.instr    = instr_i;
        dec.rs1      = instr_i[19:15];
        dec.rs2      = instr_i[24:20];
        dec.rd       = instr_i[11:7];
        dec.op_class = CLS_ILLEGAL;
        legal        = 1'b1;

        unique case (opcode)
            OPC_OP, OPC_OP32: begin
                dec.rs1_r_v = 1'b1;
                dec.rs2_r_v = 1'b1;
                dec.irf_w_v = 1'b1;
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000)
                    dec.op_class = (opcode == OPC_OP) ? CLS_ALU : CLS_ALU_W;
`ifdef BP_BE_DECODE_RV64M_EN
                // RV64M has no 32-bit forms of mulh/mulhsu/mulhu.
                else if (funct7 == 7'b0000001 &&
                         !(opcode == OPC_OP32 && funct3 inside {3'b001, 3'b010, 3'b011}))
                    dec.op_class = CLS_MULDIV;
`endif
                else
                    legal = 1'b0;
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                dec.op_class = (opcode == OPC_OP_IMM) ? CLS_ALU : CLS_ALU_W;
                dec.rs1_r_v  = 1'b1;
                dec.irf_w_v  = 1'b1;
                dec.imm      = imm_i;
                // Word shifts carry only a 5-bit shamt.
                if (opcode == OPC_OP_IMM32 && (funct3 == 3'b001 || funct3 == 3'b101))
                    dec.imm[5] = 1'b0;
            end
            OPC_LOAD: begin
                dec.op_class = CLS_LOAD;
                dec.rs1_r_v  = 1'b1;
                dec.irf_w_v  = 1'b1;
                dec.imm      = imm_i;
            end
            OPC_STORE: begin
                dec.op_class = CLS_STORE;
                dec.rs1_r_v  = 1'b1;
                dec.rs2_r_v  = 1'b1;
                dec.imm      = imm_s;
            end
            OPC_BRANCH: begin
                dec.op_class = CLS_BRANCH;
                dec.rs1_r_v  = 1'b1;
                dec.rs2_r_v  = 1'b1;
                dec.imm      = imm_b;
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    legal = 1'b0;
            end
            OPC_JAL: begin
                dec.op_class = CLS_JAL;
                dec.irf_w_v  = 1'b1;
                dec.imm      = imm_j;
            end
            OPC_JALR: begin
                dec.op_class = CLS_JALR;
                dec.rs1_r_v  = 1'b1;
                dec.irf_w_v  = 1'b1;
                dec.imm      = imm_i;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.op_class = (opcode == OPC_LUI) ? CLS_LUI : CLS_AUIPC;
                dec.irf_w_v  = 1'b1;
                dec.imm      = imm_u;
            end
            OPC_SYSTEM, OPC_FENCE: begin
                dec.op_class = CLS_SYS;
                dec.rs1_r_v  = 1'b1;
                dec.irf_w_v  = (opcode == OPC_SYSTEM);
                dec.imm      = imm_i;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.op_class = CLS_ILLEGAL;
            dec.rs1_r_v  = 1'b0;
            dec.rs2_r_v  = 1'b0;
            dec.irf_w_v  = 1'b0;
        end
        dec.illegal = !legal;
        if (dec.rd == '0)
            dec.irf_w_v = 1'b0;
    end

    // Two-entry FIFO; ready_o is registered so it never depends on yumi_i combinationally.
    uop_t       mem [els_p];
    logic       rd_ptr, wr_ptr;
    logic [1:0] count, count_n;
    logic       ready_r;
    logic       enq, deq;

    assign v_o     = (count != 2'd0);
    assign ready_o = ready_r;
    assign enq     = v_i && ready_r && !flush_i;
    assign deq     = yumi_i && v_o && !flush_i;
    assign count_n = count + {1'b0, enq} - {1'b0, deq};

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset_i || flush_i) begin
            count   <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            count   <= count_n;
            ready_r <= (count_n != 2'd2);
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: storage is small, so it is cleared on reset for deterministic outputs.
        if (reset_i) begin
            for (int i = 0; i < els_p; i++)
                mem[i] <= '0;
        end else if (enq) begin
            mem[wr_ptr] <= dec;
        end
    end

    assign pc_o       = mem[rd_ptr].pc;
    assign instr_o    = mem[rd_ptr].instr;
    assign rs1_addr_o = mem[rd_ptr].rs1;
    assign rs2_addr_o = mem[rd_ptr].rs2;
    assign rd_addr_o  = mem[rd_ptr].rd;
    assign rs1_r_v_o  = mem[rd_ptr].rs1_r_v;
    assign rs2_r_v_o  = mem[rd_ptr].rs2_r_v;
    assign irf_w_v_o  = mem[rd_ptr].irf_w_v;
    assign imm_o      = mem[rd_ptr].imm;
    assign op_class_o = mem[rd_ptr].op_class;
    assign illegal_o  = mem[rd_ptr].illegal;

endmodule

// File: doc/bp_be_instr_decode_stage.md
Name: bp_be_instr_decode_stage

Overview:
Backend decode stage that accepts raw 32-bit RV64 instructions with their PC from the fetch/issue side and splits them into the standard instruction fields: funct7, rs2, rs1, funct3, rd, opcode. It produces a decoded micro-op: register addresses, read/write enables, a sign-extended 64-bit immediate, an op class and an illegal flag. Each micro-op is buffered in a 2-entry output queue ahead of the register-read/dispatch stage. Inputs use a valid/ready handshake; outputs use a valid/yumi handshake.

Parameters:
eaddr_width_p, 64, PC width.
instr_width_p, 32, instruction width.
reg_addr_width_p, 5, register address width.
els_p, 2, output queue depth. Only 2 is supported.

Ports:
clk_i  in  1  clock.
reset_i  in  1  synchronous active-high reset.
flush_i  in  1  discard all buffered micro-ops.
v_i  in  1  instruction valid.
ready_o  out  1  stage can accept; registered, equals queue not full.
instr_i  in  32  raw instruction.
pc_i  in  64  instruction PC.
v_o  out  1  micro-op valid at head of queue.
yumi_i  in  1  consumer takes head; legal only when v_o=1.
pc_o  out  64  PC of head.
instr_o  out  32  raw instruction of head.
rs1_addr_o  out  5  rs1 field.
rs2_addr_o  out  5  rs2 field.
rd_addr_o  out  5  rd field.
rs1_r_v_o  out  1  rs1 is read.
rs2_r_v_o  out  1  rs2 is read.
irf_w_v_o  out  1  integer RF write; forced 0 when rd=0.
imm_o  out  64  sign-extended immediate.
op_class_o  out  4  op class.
illegal_o  out  1  illegal instruction.

Behaviour:
- Enqueue when v_i & ready_o. Decode is purely combinational from instr_i; the decoded record is written into the queue at the clock edge.
- Latency: instruction accepted in cycle N is visible on v_o/outputs in cycle N+1 if the queue was empty.
- Dequeue when yumi_i. Asserting yumi_i with v_o=0 is a protocol violation; the bench asserts on it.
- Queue state:
  - Counter 0..2, read pointer and write pointer, each 1 bit and wrapping.
  - ready_o = (count != 2); it is independent of yumi_i in the same cycle.
  - Full + yumi: count drops to 1 and ready_o=1 next cycle.
  - Simultaneous enqueue and dequeue with count=1 leaves count=1.
  - Order is strictly FIFO.
- flush_i: next cycle count=0 and pointers=0. Flush has priority; a same-cycle enqueue is dropped and a same-cycle yumi is ignored.
- Reset: count=0, pointers=0, v_o=0, ready_o=1. Data outputs are don't-care while v_o=0; the registered storage resets to 0.
- Reset asserted mid-operation: everything is discarded, same as power-up.
- op_class_o encoding, keyed on opcode:
  - 0 ALU: 0010011, 0110011.
  - 1 ALU-W: 0011011, 0111011.
  - 2 MULDIV.
  - 3 LOAD: 0000011.
  - 4 STORE: 0100011.
  - 5 BRANCH: 1100011.
  - 6 JAL: 1101111.
  - 7 JALR: 1100111.
  - 8 LUI: 0110111.
  - 9 AUIPC: 0010111.
  - 10 SYS/FENCE: 1110011, 0001111.
  - 15 ILLEGAL.
- Illegal conditions, all giving op_class=15, illegal_o=1 and all r_v/w_v=0:
  - Any other opcode, or low two bits != 11.
  - funct7 not in {0000000, 0100000} for OP/OP-32.
  - Branch funct3 of 010 or 011.
- Immediate formats, all sign-extended from instr[31] to 64 bits:
  - I-type: LOAD, OP-IMM, JALR, SYS.
  - S-type: STORE.
  - B-type: BRANCH, imm[0]=0.
  - U-type: LUI/AUIPC, imm[11:0]=0.
  - J-type: JAL.
  - R-type: imm=0.
- Shift-immediates keep the 6-bit shamt (5-bit for OP-IMM-32) in imm_o[5:0]. imm_o[10] reflects the arithmetic-shift bit as in I-type.
- Read/write enables:
  - rs1_r_v: all except LUI, AUIPC, JAL, illegal.
  - rs2_r_v: R-type, STORE, BRANCH.
  - irf_w_v: all except STORE, BRANCH, FENCE, illegal, with rd!=0.

Optional Feature:
BP_BE_DECODE_RV64M_EN.
- Defined: OP/OP-32 with funct7=0000001 decode as op_class=2 with rs1/rs2 read and rd written. For OP-32, funct3 in {001,010,011} is illegal.
- Undefined: funct7=0000001 is illegal (op_class=15, illegal_o=1).

Test Plan:
- Reset, then v_i=1, instr=0x00500093, pc=0x80000000 → next cycle v_o=1, rd=1, rs1=0, imm=5, op_class=0, irf_w_v=1, rs2_r_v=0, pc_o=0x80000000.
- instr=0xFE208EE3 (beq x1,x2,-4) → rs1=1, rs2=2, imm=0xFFFFFFFFFFFFFFFC, op_class=5, irf_w_v=0.
- instr=0x022081B3 (mul x3,x1,x2) → with macro: op_class=2, illegal=0. Without macro: op_class=15, illegal=1. instr=0x00000000 → illegal=1 in both builds.
- yumi_i=0, present 3 instructions back-to-back → first 2 accepted, ready_o=0 from cycle 3, third held. Then yumi_i=1 for 3 cycles → the 3 instructions drain in issue order and ready_o returns to 1.
- Queue full, then flush_i=1 with v_i=1 and yumi_i=1 in the same cycle → next cycle v_o=0, ready_o=1, and the flushed-cycle instruction never appears.
- addi x0,x0,1 (0x00100013) → irf_w_v=0. lui x5,0x80000 (0x800002B7) → imm=0xFFFFFFFF80000000, rs1_r_v=0.
